multicycle_control: RTL
=======================

# multicycle_control

Moore-style sequencing controller that turns the existing single-cycle MIPS datapath into a multicycle machine sharing one ALU and one unified memory across fetch, decode, execute, memory and write-back steps. It reads the opcode from the instruction register and each cycle drives the datapath strobes and mux selects: PC, IR, memory, register file, ALU-source muxes, ALU control and PC source. It also stalls on a memory-ready handshake and traps on unknown opcodes.

## Interface
- WAIT_LIMIT, 0 — max consecutive not-ready cycles tolerated in a memory state; 0 disables the timeout
- clk  in  1  — rising-edge clock
- rst_n  in  1  — asynchronous, active-low reset
- opcode  in  6  — instruction[31:26] from the instruction register
- mem_ready  in  1  — memory completes the current access this cycle
- pc_write, pc_write_cond  out  1  — PC load unconditional / gated by ALU zero
- i_or_d  out  1  — memory address select: 0 = PC, 1 = ALU output register
- mem_read, mem_write  out  1  — memory strobes
- ir_write  out  1  — instruction register load
- mem_to_reg  out  1  — write-back data select: 1 = memory data register
- reg_dst  out  1  — write-register select: 1 = rd, 0 = rt
- reg_write  out  1  — register file write enable
- alu_src_a  out  1  — 0 = PC, 1 = register A
- alu_src_b  out  2  — 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
- alu_op  out  2  — to ALU control: 00 add, 01 sub, 10 funct
- pc_source  out  2  — 00 ALU result, 01 ALU output register, 10 jump target
- state  out  4  — current state, for debug
- instr_done  out  1  — high in the last cycle of each instruction
- illegal  out  1  — high while in TRAP

## Operation
- States and encodings: RESET=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12, TRAP=15.
- In any state, every output not listed for that state is 0.
- RESET: all outputs 0. Next state: FETCH.
- FETCH: mem_read=1, alu_src_b=01. ir_write and pc_write are asserted only when mem_ready=1. On mem_ready, go to DECODE; otherwise stay.
- DECODE: alu_src_b=11. Next state by opcode:
  - 000000 → R_EXEC
  - 100011 or 101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDI_EXEC (only when the macro is enabled)
  - any other opcode → TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10. Go to MEM_RD for lw (100011), MEM_WR for sw (101011).
- MEM_RD: mem_read=1, i_or_d=1. On mem_ready go to MEM_WB; otherwise stay.
- MEM_WB: reg_write=1, mem_to_reg=1, instr_done=1. Next: FETCH.
- MEM_WR: mem_write=1, i_or_d=1. instr_done=mem_ready. On mem_ready go to FETCH; otherwise stay.
- R_EXEC: alu_src_a=1, alu_op=10. Next: R_WB.
- R_WB: reg_write=1, reg_dst=1, instr_done=1. Next: FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Next: FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next: FETCH.
- TRAP: illegal=1. Stays in TRAP until rst_n is asserted.
- Wait counter (8 bits, saturating):
  - Increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0.
  - Clears on any state change.
  - With WAIT_LIMIT≠0, when the count equals WAIT_LIMIT and mem_ready=0, the next state is TRAP.
  - If mem_ready=1 in that same cycle, the ready transition wins.

## Timing
- The state register updates on the rising edge of clk. Outputs are decoded combinationally from state; ir_write, pc_write and instr_done are additionally qualified by mem_ready where stated.
- rst_n low forces state=RESET immediately, without waiting for a clock edge. All outputs go to 0 and the wait counter clears. This applies even mid-instruction.
- opcode is sampled only in DECODE and MEM_ADDR. The IR is stable there because ir_write is asserted only in FETCH.
- Latency with mem_ready held at 1, measured from FETCH through the instr_done cycle:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
- Each cycle with mem_ready=0 in a memory state adds one cycle.

## Configuration
- MULTICYCLE_ADDI_EN defined: opcode 001000 takes DECODE→ADDI_EXEC→ADDI_WB→FETCH.
  - ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1.
- MULTICYCLE_ADDI_EN undefined: states 11 and 12 are not built, and opcode 001000 goes to TRAP.

## Structure
- Shared package mc_pkg holds:
  - the state encodings;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - alu_op, alu_src_b and pc_source code constants.
- One sub-module, mc_wait_timer, contains the saturating wait counter and timeout compare. Its signals are clk, rst_n, waiting, clear and timeout.

## Test plan
- R-type, mem_ready=1: state sequence after reset release is 0,1,2,7,8,1. reg_write=1 and reg_dst=1 only in state 8. instr_done pulses once.
- lw with mem_ready=0 for 3 cycles in MEM_RD: mem_read=1 and i_or_d=1 for 4 cycles, then MEM_WB with reg_write=1 and mem_to_reg=1. Total 8 cycles.
- beq: cycle 3 shows pc_write_cond=1, pc_source=01, alu_op=01. j: pc_write=1, pc_source=10. Both then return to FETCH.
- opcode 111111 → TRAP with illegal=1 and all strobes 0. Holds for 20 cycles. Recovers only on rst_n low.
- WAIT_LIMIT=4 with mem_ready stuck 0 in FETCH → TRAP after 4 wait cycles. If mem_ready rises in the 4th wait cycle instead, the controller goes to DECODE.
- rst_n asserted in R_EXEC between clock edges: state=0 and all outputs 0 immediately. With MULTICYCLE_ADDI_EN, opcode 001000 passes through states 11,12. Without it, opcode 001000 → 15.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS controller.
// Holds the state encodings, the opcode constants, the ALU/mux select codes
// and a helper that identifies the states which wait on memory.
// Optional feature macro used by the controller: MULTICYCLE_ADDI_EN.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_RESET     = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_RD    = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WR    = 4'd6,
        ST_R_EXEC    = 4'd7,
        ST_R_WB      = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JUMP      = 4'd10,
        ST_ADDI_EXEC = 4'd11,
        ST_ADDI_WB   = 4'd12,
        ST_TRAP      = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam int unsigned WAIT_W = 8;

    // States that hold a memory access open until mem_ready.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle controller and the MIPS datapath.
// master: controller side (receives opcode/mem_ready, drives strobes/selects).
// slave : datapath side (the reverse directions).
interface multicycle_control_if;

    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, instr_done, illegal
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, instr_done, illegal
    );

endinterface

// File: rtl/mc_wait_timer.sv
// Saturating count of consecutive not-ready cycles in a memory state.
// Ports: clk, rst_n (async active-low), waiting (count this cycle),
//        clear (controller changes state), timeout (count reached WAIT_LIMIT).
// WAIT_LIMIT = 0 disables the timeout.
module mc_wait_timer
    import mc_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    input  logic clear,
    output logic timeout
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(WAIT_LIMIT);

    logic [WAIT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (waiting && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = (WAIT_LIMIT != 0) && (count == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencing controller for the multicycle MIPS datapath.
// Ports: clk, rst_n (async active-low), bus (multicycle_control_if.master:
//        opcode/mem_ready in; PC/IR/memory/regfile strobes, mux selects,
//        alu_op, pc_source, debug state, instr_done, illegal out).
// Build option: define MULTICYCLE_ADDI_EN to add the addi path (states 11/12);
// without it opcode 001000 traps.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_control_if.master        bus
);

    state_t state_q;
    state_t state_d;
    logic   waiting;
    logic   timeout;

    assign waiting = is_wait_state(state_q) && !bus.mem_ready;

    mc_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .waiting (waiting),
        .clear   (state_d != state_q),
        .timeout (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. In memory states mem_ready is checked before the timeout so
    // a completion in the limit cycle still proceeds normally.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:    state_d = ST_FETCH;
            ST_FETCH: begin
                if (bus.mem_ready)  state_d = ST_DECODE;
                else if (timeout)   state_d = ST_TRAP;
            end
            ST_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:      state_d = ST_R_EXEC;
                    OP_LW, OP_SW:  state_d = ST_MEM_ADDR;
                    OP_BEQ:        state_d = ST_BRANCH;
                    OP_J:          state_d = ST_JUMP;
`ifdef MULTICYCLE_ADDI_EN
                    OP_ADDI:       state_d = ST_ADDI_EXEC;
`endif
                    default:       state_d = ST_TRAP;
                endcase
            end
            ST_MEM_ADDR: begin
                if (bus.opcode == OP_LW)       state_d = ST_MEM_RD;
                else if (bus.opcode == OP_SW)  state_d = ST_MEM_WR;
                else                           state_d = ST_TRAP;
            end
            ST_MEM_RD: begin
                if (bus.mem_ready)  state_d = ST_MEM_WB;
                else if (timeout)   state_d = ST_TRAP;
            end
            ST_MEM_WB:   state_d = ST_FETCH;
            ST_MEM_WR: begin
                if (bus.mem_ready)  state_d = ST_FETCH;
                else if (timeout)   state_d = ST_TRAP;
            end
            ST_R_EXEC:   state_d = ST_R_WB;
            ST_R_WB:     state_d = ST_FETCH;
            ST_BRANCH:   state_d = ST_FETCH;
            ST_JUMP:     state_d = ST_FETCH;
`ifdef MULTICYCLE_ADDI_EN
            ST_ADDI_EXEC: state_d = ST_ADDI_WB;
            ST_ADDI_WB:   state_d = ST_FETCH;
`endif
            ST_TRAP:     state_d = ST_TRAP;
            default:     state_d = ST_TRAP;
        endcase
    end

    // Outputs decoded from state; a few strobes are qualified by mem_ready.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_REG;
        bus.alu_op        = ALU_ADD;
        bus.pc_source     = PCSRC_ALU;
        bus.instr_done    = 1'b0;
        bus.illegal       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            ST_DECODE: begin
                bus.alu_src_b = SRCB_IMM_SH;
            end
            ST_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
            end
            ST_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                bus.mem_write  = 1'b1;
                bus.i_or_d     = 1'b1;
                bus.instr_done = bus.mem_ready;
            end
            ST_R_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_FUNCT;
            end
            ST_R_WB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 1'b1;
                bus.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALU_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = PCSRC_ALUOUT;
                bus.instr_done    = 1'b1;
            end
            ST_JUMP: begin
                bus.pc_write   = 1'b1;
                bus.pc_source  = PCSRC_JUMP;
                bus.instr_done = 1'b1;
            end
`ifdef MULTICYCLE_ADDI_EN
            ST_ADDI_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_op    = ALU_ADD;
            end
            ST_ADDI_WB: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
            end
`endif
            ST_TRAP: begin
                bus.illegal = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.state = state_q;

endmodule
